// File: rtl/fma16_align_if.sv
// Operand/result handshake bundle for the FMA16 addend-alignment unit.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface fma16_align_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  pe;
    logic [4:0]  ze;
    logic [10:0] zm;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] am;
    logic        asticky;
    logic        kill_prod;
    logic [6:0]  acnt;

    modport master (
        output in_valid, pe, ze, zm, out_ready,
        input  in_ready, out_valid, am, asticky, kill_prod, acnt
    );

    modport slave (
        input  in_valid, pe, ze, zm, out_ready,
        output in_ready, out_valid, am, asticky, kill_prod, acnt
    );
endinterface

// File: rtl/fma16_align.sv
// Iterative addend alignment: right-shifts {zm, 23'b0} by the clamped exponent difference, collecting sticky.
// Define FMA16_ALIGN_FAST_EN to do the whole shift in one SHIFT cycle instead of STEP bits per cycle.
module fma16_align #(
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    fma16_align_if.slave  bus,
    output logic [1:0]    dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state_q;
    logic [33:0] am_q;
    logic        sticky_q;
    logic        kill_q;
    logic [6:0]  acnt_q;
    logic [5:0]  rem_q;

    logic [6:0]  acnt_d;
    logic [5:0]  n_d;
    logic [5:0]  s_d;
    logic [33:0] mask_d;
    logic [33:0] am_d;
    logic        sticky_d;

    always_comb begin
        acnt_d = bus.pe - {2'b00, bus.ze} + 7'd12;
        // Negative count: addend dominates; positive counts past 34 just flush everything into sticky.
        if (acnt_d[6]) begin
            n_d = 6'd0;
        end else if (acnt_d > 7'd34) begin
            n_d = 6'd34;
        end else begin
            n_d = acnt_d[5:0];
        end
`ifdef FMA16_ALIGN_FAST_EN
        s_d = rem_q;
`else
        s_d = (rem_q > STEP_W) ? STEP_W : rem_q;
`endif
        mask_d   = ~({34{1'b1}} << s_d);
        am_d     = am_q >> s_d;
        sticky_d = sticky_q | (|(am_q & mask_d));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            am_q     <= '0;
            sticky_q <= 1'b0;
            kill_q   <= 1'b0;
            acnt_q   <= '0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        acnt_q   <= acnt_d;
                        am_q     <= {bus.zm, 23'b0};
                        sticky_q <= 1'b0;
                        kill_q   <= acnt_d[6];
                        rem_q    <= n_d;
                        state_q  <= (n_d == 6'd0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    am_q     <= am_d;
                    sticky_q <= sticky_d;
                    rem_q    <= rem_q - s_d;
                    if (rem_q == s_d) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.am        = am_q;
    assign bus.asticky   = sticky_q;
    assign bus.kill_prod = kill_q;
    assign bus.acnt      = acnt_q;
    assign dbg_state_o   = state_q;
endmodule
